// File: rtl/ldpc_rx_check.sv
// ldpc_rx_check: collects an LDPC codeword, checks its syndrome against an external H-row ROM, streams the info bits
module ldpc_rx_check #(
    parameter int N = 1024,
    parameter int W = 8,
    parameter int M = 512,
    parameter int K = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rst_c,
    input  logic [W-1:0]             din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [$clog2(M)-1:0]     h_addr,
    input  logic [N-1:0]             h_row,
    output logic [W-1:0]             dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     syn_ok,
    output logic [$clog2(M+1)-1:0]   syn_weight,
    output logic                     busy
);
    localparam int AW = $clog2(M);
    localparam int SW = $clog2(M+1);
    localparam int CW = $clog2(M + N/W + K/W + 2);
    typedef enum logic [1:0] {LOAD, CHECK, OUT} state_t;
    state_t r_state, w_next;
    logic [N-1:0]  r_cw;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_h_addr;
    logic [SW-1:0] r_syn_weight;
    logic          r_syn_ok;
    logic          w_p, w_in_xfer, w_out_xfer, w_in_done, w_out_done, w_check_done;
    assign w_in_xfer    = r_state == LOAD && din_valid;
    assign w_out_xfer   = r_state == OUT && dout_ready;
    assign w_in_done    = w_in_xfer && r_cnt == CW'(N/W-1);
    assign w_out_done   = w_out_xfer && r_cnt == CW'(K/W-1);
    assign w_check_done = r_state == CHECK && r_cnt == CW'(M);
    assign w_p          = ^(h_row & r_cw);
    assign h_addr       = r_h_addr;
    assign syn_ok       = r_syn_ok;
    assign syn_weight   = r_syn_weight;
    // state register; the synchronous clear overrides every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LOAD;
        else        r_state <= !rst_c ? LOAD : w_next;
    end
    // next state and handshake/stream outputs
    always_comb begin
        w_next     = r_state;
        din_ready  = r_state == LOAD;
        dout_valid = r_state == OUT;
        busy       = r_state != LOAD;
        dout       = r_state == OUT ? r_cw[W-1:0] : '0;
        dout_last  = r_state == OUT && r_cnt == CW'(K/W-1);
        if (w_in_done)    w_next = CHECK;
        if (w_check_done) w_next = OUT;
        if (w_out_done)   w_next = LOAD;
    end
    // datapath: codeword shift-in, row walk with 1-cycle ROM latency, shift-out of info beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cw         <= '0;
            r_cnt        <= '0;
            r_h_addr     <= '0;
            r_syn_weight <= '0;
            r_syn_ok     <= 1'b0;
        end else if (!rst_c) begin
            r_cw         <= '0;
            r_cnt        <= '0;
            r_h_addr     <= '0;
            r_syn_weight <= '0;
            r_syn_ok     <= 1'b0;
        end else begin
            if (w_in_xfer)
                r_cw <= {din, r_cw[N-1:W]};
            else if (w_out_xfer)
                r_cw <= r_cw >> W;
            if (w_in_xfer || w_out_xfer || r_state == CHECK)
                r_cnt <= (w_in_done || w_check_done || w_out_done) ? '0 : r_cnt + 1'b1;
            if (w_in_done)
                r_h_addr <= '0;
            else if (r_state == CHECK && r_cnt < CW'(M-1))
                r_h_addr <= r_h_addr + 1'b1;
            if (w_in_done)
                r_syn_weight <= '0;
            else if (r_state == CHECK && r_cnt != '0 && r_syn_weight != SW'(M))
                r_syn_weight <= r_syn_weight + SW'(w_p);
            if (w_check_done)
                r_syn_ok <= r_syn_weight == '0 && !w_p;
        end
    end
endmodule

// File: tb/tb_ldpc_rx_check.sv
// tb_ldpc_rx_check: directed scenarios for the LDPC receive-side syndrome checker
module tb_ldpc_rx_check;
    localparam int N  = 1024;
    localparam int W  = 8;
    localparam int M  = 512;
    localparam int K  = 512;
    localparam int AW = $clog2(M);
    localparam int SW = $clog2(M+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rst_c = 1'b1;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [AW-1:0] h_addr;
    logic [N-1:0]  h_row = '0;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          dout_last;
    logic          syn_ok;
    logic [SW-1:0] syn_weight;
    logic          busy;

    int tests = 0;
    int failed = 0;
    logic [K-1:0] msg_a, msg_b;
    logic [N-1:0] cw_a, cw_b;

    ldpc_rx_check #(.N(N), .W(W), .M(M), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .rst_c(rst_c),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .h_addr(h_addr), .h_row(h_row),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .syn_ok(syn_ok), .syn_weight(syn_weight), .busy(busy)
    );

    always #5 clk = ~clk;

    // H rows: identity over the parity part plus two info taps; rows 5 and 9 also touch bit 700
    function automatic logic [N-1:0] hrow(input int r);
        logic [N-1:0] v;
        v = '0;
        v[K + r] = 1'b1;
        v[r % K] = 1'b1;
        v[(7*r + 3) % K] = 1'b1;
        if (r == 5 || r == 9) v[700] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) h_row <= hrow(int'(h_addr));

    function automatic logic [N-1:0] encode(input logic [K-1:0] msg);
        logic [N-1:0] c;
        c = '0;
        c[K-1:0] = msg;
        for (int r = 0; r < M; r++) c[K + r] = msg[r] ^ msg[(7*r + 3) % K];
        c[K + 5] = c[K + 5] ^ c[700];
        c[K + 9] = c[K + 9] ^ c[700];
        return c;
    endfunction

    function automatic logic [K-1:0] rand_msg();
        logic [K-1:0] m;
        for (int i = 0; i < K/32; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    task automatic send(input logic [N-1:0] cw, input bit gaps, input bit keep, input int nb);
        int t;
        for (int b = 0; b < nb; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                @(negedge clk);
            end
            din = cw[b*W +: W];
            din_valid = 1'b1;
            t = 0;
            while (!din_ready && t < 4000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 4000) begin
                tests++;
                failed++;
                $display("FAIL send_timeout: beat %0d never accepted, din_ready=%0b required 1", b, din_ready);
                din_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (!keep) din_valid = 1'b0;
    endtask

    task automatic recv(input logic [K-1:0] exp, input bit rnd, input bit exp_ok, input int exp_wt, input bit prev_ok);
        int t;
        int j;
        int held_bad;
        t = 0;
        j = 0;
        held_bad = 0;
        while (!dout_valid && t < 3000) begin
            if (syn_ok !== prev_ok) held_bad++;
            @(negedge clk);
            t++;
        end
        tests++;
        if (t >= 3000 || held_bad != 0) begin
            failed++;
            $display("FAIL syn_hold: waited=%0d cycles, syn_ok deviated %0d times, required syn_ok=%0b held until dout", t, held_bad, prev_ok);
        end
        if (t >= 3000) return;
        tests++;
        if (syn_ok !== exp_ok) begin
            failed++;
            $display("FAIL syn_ok: got %0b required %0b", syn_ok, exp_ok);
        end
        tests++;
        if (syn_weight !== SW'(exp_wt)) begin
            failed++;
            $display("FAIL syn_weight: got %0d required %0d", syn_weight, exp_wt);
        end
        t = 0;
        while (j < K/W && t < 5000) begin
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tests++;
            if (dout_valid !== 1'b1 || dout !== exp[j*W +: W] || dout_last !== (j == K/W-1) || din_ready !== 1'b0) begin
                failed++;
                $display("FAIL dout_beat%0d: valid=%0b dout=%02h last=%0b din_ready=%0b required valid=1 dout=%02h last=%0b din_ready=0",
                         j, dout_valid, dout, dout_last, din_ready, exp[j*W +: W], j == K/W-1);
            end
            if (dout_ready) j++;
            @(negedge clk);
            t++;
        end
        dout_ready = 1'b0;
        tests++;
        if (j != K/W || dout_valid !== 1'b0 || din_ready !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL out_end: beats=%0d dout_valid=%0b din_ready=%0b busy=%0b required beats=%0d 0 1 0",
                     j, dout_valid, din_ready, busy, K/W);
        end
    endtask

    task automatic check_cleared(input string name);
        tests++;
        if (din_ready !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0 || dout !== '0 || dout_last !== 1'b0 ||
            syn_ok !== 1'b0 || syn_weight !== '0 || h_addr !== '0) begin
            failed++;
            $display("FAIL %s: din_ready=%0b busy=%0b dout_valid=%0b dout=%02h last=%0b syn_ok=%0b wt=%0d h_addr=%0d required 1 0 0 00 0 0 0 0",
                     name, din_ready, busy, dout_valid, dout, dout_last, syn_ok, syn_weight, h_addr);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_cleared("reset_active");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_cleared("reset_released");
    endtask

    task automatic test_zero();
        send('0, 1'b0, 1'b0, N/W);
        recv('0, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_encoded();
        msg_a = rand_msg();
        cw_a = encode(msg_a);
        send(cw_a, 1'b0, 1'b0, N/W);
        recv(msg_a, 1'b0, 1'b1, 0, 1'b1);
    endtask

    task automatic test_flipped();
        cw_b = cw_a;
        cw_b[700] = ~cw_b[700];
        send(cw_b, 1'b0, 1'b0, N/W);
        recv(msg_a, 1'b0, 1'b0, 3, 1'b1);
    endtask

    task automatic test_stall();
        msg_b = rand_msg();
        send(encode(msg_b), 1'b1, 1'b0, N/W);
        recv(msg_b, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_rst_c();
        send(encode(rand_msg()), 1'b0, 1'b0, 60);
        rst_c = 1'b0;
        @(negedge clk);
        rst_c = 1'b1;
        check_cleared("rst_c_load");
        send(encode(msg_b), 1'b0, 1'b0, N/W);
        repeat (200) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || h_addr !== AW'(200) || din_ready !== 1'b0 || dout_valid !== 1'b0) begin
            failed++;
            $display("FAIL check_cycle200: busy=%0b h_addr=%0d din_ready=%0b dout_valid=%0b required 1 200 0 0",
                     busy, h_addr, din_ready, dout_valid);
        end
        rst_c = 1'b0;
        @(negedge clk);
        rst_c = 1'b1;
        check_cleared("rst_c_check");
        send(encode(msg_a), 1'b0, 1'b0, N/W);
        recv(msg_a, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        cw_a = encode(msg_a);
        cw_a[700] = ~cw_a[700];
        cw_b = encode(msg_b);
        fork
            begin
                send(cw_a, 1'b0, 1'b1, N/W);
                send(cw_b, 1'b0, 1'b0, N/W);
            end
        join_none
        recv(msg_a, 1'b0, 1'b0, 3, 1'b1);
        recv(msg_b, 1'b0, 1'b1, 0, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", failed);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero();
        test_encoded();
        test_flipped();
        test_stall();
        test_rst_c();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
